// File: rtl/window_gen_if.sv
// Bundle of the window generator's control inputs and window status outputs.
// The master side (frequency-path controller) drives the control fields;
// the slave side (window_gen) drives the gate, the strobes and the sequence count.
interface window_gen_if #(
  parameter int CNT_W = 32,
  parameter int SEQ_W = 16
);
  logic             enable;
  logic             mode;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] win_len;

  logic             gate;
  logic             win_start;
  logic             win_done;
  logic             win_abort;
  logic             len_err;
  logic             busy;
  logic [SEQ_W-1:0] win_seq;

  modport master (
    output enable, mode, start, abort, win_len,
    input  gate, win_start, win_done, win_abort, len_err, busy, win_seq
  );

  modport slave (
    input  enable, mode, start, abort, win_len,
    output gate, win_start, win_done, win_abort, len_err, busy, win_seq
  );
endinterface

// File: rtl/window_gen.sv
// Measurement-window generator for the ring-oscillator frequency path.
// Produces a gate of programmable length, a fixed guard gap between windows
// for counter readout, single-cycle start/done/abort/len_err strobes and a
// wrapping count of completed windows. Every output comes straight from a flop.
module window_gen #(
  parameter int CNT_W       = 32,
  parameter int SEQ_W       = 16,
  parameter int DEFAULT_LEN = 10000,
  parameter int MIN_LEN     = 2,
  parameter int GAP_CYC     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  window_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEFAULT_LEN_C = CNT_W'(DEFAULT_LEN);
  localparam logic [CNT_W-1:0] MIN_LEN_C     = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] GAP_LAST_C    = CNT_W'(GAP_CYC - 1);

  state_t           state_q;
  logic [CNT_W-1:0] ct_q;
  logic [CNT_W-1:0] len_q;
  logic             mode_q;
  logic             gate_q;
  logic             win_start_q;
  logic             win_done_q;
  logic             win_abort_q;
  logic             len_err_q;
  logic             busy_q;
  logic [SEQ_W-1:0] win_seq_q;

  logic             kill;
  logic             clamp;
  logic             launch;
  logic [CNT_W-1:0] len_d;
  logic [CNT_W-1:0] run_last;

  // Trigger and length-selection decode shared by the IDLE and end-of-gap launch paths
  always_comb begin
    kill     = bus.abort || !bus.enable;
    clamp    = (bus.win_len < MIN_LEN_C);
    len_d    = clamp ? DEFAULT_LEN_C : bus.win_len;
    run_last = len_q - CNT_W'(1);
    launch   = 1'b0;
    if (state_q == IDLE) begin
      launch = bus.enable && !bus.abort && (!bus.mode || bus.start);
    end else if (state_q == GAP) begin
      launch = (ct_q == GAP_LAST_C) && !kill && !mode_q;
    end
  end

  // Window sequencer: state, cycle counter, latched length/mode and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ct_q        <= '0;
      len_q       <= DEFAULT_LEN_C;
      mode_q      <= 1'b0;
      gate_q      <= 1'b0;
      win_start_q <= 1'b0;
      win_done_q  <= 1'b0;
      win_abort_q <= 1'b0;
      len_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      win_seq_q   <= '0;
    end else begin
      win_start_q <= 1'b0;
      win_done_q  <= 1'b0;
      win_abort_q <= 1'b0;
      len_err_q   <= 1'b0;
      if (launch) begin
        state_q     <= RUN;
        ct_q        <= '0;
        len_q       <= len_d;
        mode_q      <= bus.mode;
        gate_q      <= 1'b1;
        win_start_q <= 1'b1;
        len_err_q   <= clamp;
        busy_q      <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            gate_q <= 1'b0;
            busy_q <= 1'b0;
          end
          RUN: begin
            if (kill) begin
              state_q     <= IDLE;
              ct_q        <= '0;
              gate_q      <= 1'b0;
              win_abort_q <= 1'b1;
              busy_q      <= 1'b0;
            end else if (ct_q == run_last) begin
              state_q    <= GAP;
              ct_q       <= '0;
              gate_q     <= 1'b0;
              win_done_q <= 1'b1;
              win_seq_q  <= win_seq_q + SEQ_W'(1);
            end else begin
              ct_q <= ct_q + CNT_W'(1);
            end
          end
          GAP: begin
            if (kill || (ct_q == GAP_LAST_C)) begin
              state_q <= IDLE;
              ct_q    <= '0;
              busy_q  <= 1'b0;
            end else begin
              ct_q <= ct_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            ct_q    <= '0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.gate      = gate_q;
  assign bus.win_start = win_start_q;
  assign bus.win_done  = win_done_q;
  assign bus.win_abort = win_abort_q;
  assign bus.len_err   = len_err_q;
  assign bus.busy      = busy_q;
  assign bus.win_seq   = win_seq_q;

endmodule

// File: tb/tb_window_gen.sv
// Directed testbench for window_gen: continuous and one-shot windows, length
// changes mid-window, length clamping, abort paths, sequence wrap and async reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_window_gen;

  localparam int CNT_W = 32;
  localparam int SEQ_W = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  window_gen_if #(.CNT_W(CNT_W), .SEQ_W(SEQ_W)) bus ();

  window_gen #(
    .CNT_W      (CNT_W),
    .SEQ_W      (SEQ_W),
    .DEFAULT_LEN(8),
    .MIN_LEN    (2),
    .GAP_CYC    (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // flags = {gate, win_start, win_done, win_abort, len_err, busy}
  logic [5:0] obs;
  assign obs = {bus.gate, bus.win_start, bus.win_done, bus.win_abort, bus.len_err, bus.busy};

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    bus.enable  = 1'b0;
    bus.mode    = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.win_len = '0;
    rst_n       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.enable  = 1'b0;
    bus.mode    = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.win_len = '0;
    rst_n       = 1'b0;
    #3;
    checks++;
    if (obs !== 6'b000000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b required=%b", obs, 6'b000000);
    end
    checks++;
    if (bus.win_seq !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_seq got=%0d required=0", bus.win_seq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (obs !== 6'b000000) begin
      failures++;
      $display("[TB] FAIL reset_idle got=%b required=%b", obs, 6'b000000);
    end
  endtask

  task automatic test_continuous();
    logic [5:0] exp;
    int         ph;
    int         exp_seq;
    apply_reset();
    bus.mode    = 1'b0;
    bus.win_len = 32'd10;
    bus.enable  = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      step();
      ph      = (k - 1) % 14;
      exp_seq = (k + 3) / 14;
      exp     = {ph < 10, ph == 0, ph == 10, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp || bus.win_seq !== SEQ_W'(exp_seq)) begin
        failures++;
        $display("[TB] FAIL cont k=%0d got=%b/%0d required=%b/%0d", k, obs, bus.win_seq, exp, exp_seq);
      end
    end
    bus.enable = 1'b0;
    step();
    checks++;
    if (obs !== 6'b000000 || bus.win_seq !== 2'd3) begin
      failures++;
      $display("[TB] FAIL cont_stop got=%b/%0d required=%b/3", obs, bus.win_seq, 6'b000000);
    end
  endtask

  task automatic test_oneshot();
    logic [5:0] exp;
    apply_reset();
    bus.mode    = 1'b1;
    bus.win_len = 32'd5;
    bus.enable  = 1'b1;
    bus.start   = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      bus.start = (k == 3);
      exp = {k <= 5, k == 1, k == 6, 1'b0, 1'b0, k <= 9};
      checks++;
      if (obs !== exp || bus.win_seq !== SEQ_W'(k >= 6)) begin
        failures++;
        $display("[TB] FAIL oneshot k=%0d got=%b/%0d required=%b/%0d", k, obs, bus.win_seq, exp, k >= 6);
      end
    end
  endtask

  task automatic test_len_change();
    logic [5:0] exp;
    int         exp_seq;
    apply_reset();
    bus.mode    = 1'b0;
    bus.win_len = 32'd10;
    bus.enable  = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step();
      if (k == 3) bus.win_len = 32'd20;
      exp_seq = int'(k >= 11) + int'(k >= 35);
      exp = {(k <= 10) || (k >= 15 && k <= 34), k == 1 || k == 15, k == 11 || k == 35,
             1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp || bus.win_seq !== SEQ_W'(exp_seq)) begin
        failures++;
        $display("[TB] FAIL lenchg k=%0d got=%b/%0d required=%b/%0d", k, obs, bus.win_seq, exp, exp_seq);
      end
    end
  endtask

  task automatic test_len_clamp();
    logic [5:0] exp;
    apply_reset();
    bus.mode    = 1'b1;
    bus.win_len = 32'd1;
    bus.enable  = 1'b1;
    bus.start   = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      bus.start = 1'b0;
      if (k == 13) begin
        bus.win_len = 32'd0;
        bus.start   = 1'b1;
      end
      exp = {(k <= 8) || (k == 14), k == 1 || k == 14, k == 9, 1'b0,
             k == 1 || k == 14, (k <= 12) || (k == 14)};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL clamp k=%0d got=%b required=%b", k, obs, exp);
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_abort();
    logic [5:0] exp;
    int         abort_at;
    apply_reset();
    bus.mode    = 1'b1;
    bus.win_len = 32'd10;
    bus.enable  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      abort_at  = (c == 0) ? 6 : ((c == 1) ? 10 : 4);
      bus.start = 1'b1;
      for (int k = 1; k <= abort_at + 2; k++) begin
        step();
        bus.start = 1'b0;
        if (k == abort_at) begin
          if (c == 2) bus.enable = 1'b0;
          else        bus.abort  = 1'b1;
        end
        if (k == abort_at + 1) begin
          bus.abort  = 1'b0;
          bus.enable = 1'b1;
        end
        exp = {k <= abort_at, k == 1, 1'b0, k == abort_at + 1, 1'b0, k <= abort_at};
        checks++;
        if (obs !== exp || bus.win_seq !== 2'd0) begin
          failures++;
          $display("[TB] FAIL abort c=%0d k=%0d got=%b/%0d required=%b/0", c, k, obs, bus.win_seq, exp);
        end
      end
    end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (obs !== 6'b000000) begin
      failures++;
      $display("[TB] FAIL start_abort_idle got=%b required=%b", obs, 6'b000000);
    end
  endtask

  task automatic test_seq_wrap();
    logic [SEQ_W-1:0] exp_seq [5];
    int               n;
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    n = 0;
    apply_reset();
    bus.mode    = 1'b0;
    bus.win_len = 32'd2;
    bus.enable  = 1'b1;
    for (int k = 1; k <= 40 && n < 5; k++) begin
      step();
      if (bus.win_done === 1'b1) begin
        checks++;
        if (bus.win_seq !== exp_seq[n] || k != 6 * n + 3) begin
          failures++;
          $display("[TB] FAIL seqwrap n=%0d k=%0d got=%0d required=%0d at k=%0d", n, k, bus.win_seq,
                   exp_seq[n], 6 * n + 3);
        end
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      failures++;
      $display("[TB] FAIL seqwrap_count got=%0d required=5", n);
    end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    bus.mode    = 1'b0;
    bus.win_len = 32'd10;
    bus.enable  = 1'b1;
    for (int k = 1; k <= 17; k++) step();
    checks++;
    if (obs !== 6'b100001 || bus.win_seq !== 2'd1) begin
      failures++;
      $display("[TB] FAIL midrun_pre got=%b/%0d required=%b/1", obs, bus.win_seq, 6'b100001);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b000000 || bus.win_seq !== 2'd0) begin
      failures++;
      $display("[TB] FAIL midrun_reset got=%b/%0d required=%b/0", obs, bus.win_seq, 6'b000000);
    end
    bus.enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (obs !== 6'b000000) begin
        failures++;
        $display("[TB] FAIL midrun_hold k=%0d got=%b required=%b", k, obs, 6'b000000);
      end
    end
    rst_n = 1'b1;
    step();
  endtask

  // Test sequence
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    test_reset();
    test_continuous();
    test_oneshot();
    test_len_change();
    test_len_clamp();
    test_abort();
    test_seq_wrap();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_gen.md
Name: window_gen

Overview:
Programmable measurement-window generator for the ring-oscillator frequency path. It produces a gate that the edge counter samples during, plus registered single-cycle start, done and abort strobes and a window sequence number for UART framing. Window length is runtime-programmable per window. The block supports continuous and one-shot modes, with a guard gap between windows for counter readout.

Parameters:
CNT_W, 32, width of the window-length register and internal cycle counter.
SEQ_W, 16, width of the window sequence counter.
DEFAULT_LEN, 10000, window length in clk cycles used after reset and when win_len is invalid.
MIN_LEN, 2, smallest accepted win_len; smaller values are replaced by DEFAULT_LEN.
GAP_CYC, 4, gate-low cycles between consecutive windows; legal range is 1 or more.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous, active-low reset.
enable  in  1  level; permits windows to run; deassertion aborts a running window.
mode  in  1  0 = continuous, 1 = one-shot.
start  in  1  single-cycle trigger; used in one-shot mode only.
abort  in  1  single-cycle request to kill the current window.
win_len  in  CNT_W  requested window length in clk cycles.
gate  out  1  high for exactly len_q cycles per completed window.
win_start  out  1  one-cycle pulse coincident with the first gate-high cycle.
win_done  out  1  one-cycle pulse in the first cycle after the last gate-high cycle.
win_abort  out  1  one-cycle pulse when a running window is killed.
len_err  out  1  one-cycle pulse, coincident with win_start, when win_len was clamped.
busy  out  1  high while state is RUN or GAP.
win_seq  out  SEQ_W  count of completed windows; wraps to 0.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state): state = IDLE; ct = 0; len_q = DEFAULT_LEN; gate, win_start, win_done, win_abort, len_err, busy = 0; win_seq = 0. A reset mid-window produces no win_done.
- Trigger, evaluated in IDLE, or at the end of GAP:
  - Continuous mode: enable=1 is sufficient.
  - One-shot mode: requires enable=1 and start=1 in the same cycle.
  - mode is sampled only at the trigger and held for the whole window.
- On the trigger edge:
  - state goes to RUN; gate=1; win_start=1; ct=0.
  - len_q latches win_len. If win_len < MIN_LEN (including 0), len_q = DEFAULT_LEN and len_err=1.
- RUN:
  - ct increments every cycle.
  - win_len changes during RUN have no effect until the next trigger.
  - On the edge where ct == len_q-1: gate=0, win_done=1, win_seq+1 (wraps at 2^SEQ_W-1 to 0), state goes to GAP, ct=0.
  - gate is therefore high for exactly len_q cycles.
- GAP:
  - gate=0 for exactly GAP_CYC cycles.
  - Then, if mode was continuous and enable=1, the next window starts immediately. The gate rises GAP_CYC cycles after gate fell. Otherwise state goes to IDLE.
- Abort (abort=1, or enable=0) during RUN, effective on the next edge:
  - gate=0, win_abort=1, state goes to IDLE, ct=0.
  - No win_done; win_seq unchanged.
  - This takes priority over completion in the same cycle.
- Abort during GAP: state goes to IDLE with no pulse.
- Abort in IDLE: ignored.
- start during RUN or GAP: ignored, not queued.
- Simultaneous start and abort in IDLE: abort wins; no window starts.
- Strobes: win_start, win_done, win_abort and len_err never stay high for more than 1 cycle.
- busy = (state != IDLE), registered alongside the state.

Test Plan:
- Continuous mode, win_len=10, GAP_CYC=4, enable held high → gate high for 10 cycles, low for 4, repeating. win_start and win_done are 14 cycles apart in steady state. win_seq reads 1, 2, 3 after each win_done.
- One-shot mode, win_len=5, single start pulse → gate high for exactly 5 cycles, one win_done, then IDLE with busy=0. A second start issued during RUN produces no extra window.
- win_len changed from 10 to 20 on gate cycle 3 → the current window still lasts 10 cycles; the next window lasts 20.
- win_len=1 (below MIN_LEN=2) with DEFAULT_LEN=8 → len_err pulses together with win_start; gate high for 8 cycles.
- abort asserted on gate cycle 6 of a 10-cycle window → gate low on the next edge, win_abort=1 for 1 cycle, no win_done, win_seq unchanged. Repeat with abort asserted on the final cycle: win_abort is issued, not win_done.
- SEQ_W=2, continuous mode for 5 windows → win_seq sequence 1, 2, 3, 0, 1. Asserting rst_n low mid-RUN → all outputs 0 immediately.
